multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle RV32I core. Sequences fetch/decode/execute/memory/writeback

---
 rtl/multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle RV32I core
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] opcode_i,
    input  logic       branch_taken_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic [2:0] imm_sel_o,
    output logic       alu_a_sel_o,
    output logic       alu_b_sel_o,
    output logic [1:0] wb_sel_o,
    output logic       reg_we_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Counter only ever needs to reach MEM_TIMEOUT-1
    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (MEM_TIMEOUT > 0);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      cause_q;

    logic is_load, is_opimm, is_auipc, is_store, is_op, is_lui, is_branch, is_jalr, is_jal;
    logic legal, timeout;
    logic [2:0] imm_d;

    assign is_load   = (opcode_i == OPC_LOAD);
    assign is_opimm  = (opcode_i == OPC_OPIMM);
    assign is_auipc  = (opcode_i == OPC_AUIPC);
    assign is_store  = (opcode_i == OPC_STORE);
    assign is_op     = (opcode_i == OPC_OP);
    assign is_lui    = (opcode_i == OPC_LUI);
    assign is_branch = (opcode_i == OPC_BRANCH);
    assign is_jalr   = (opcode_i == OPC_JALR);
    assign is_jal    = (opcode_i == OPC_JAL);
    assign legal     = is_load | is_opimm | is_auipc | is_store | is_op | is_lui |
                       is_branch | is_jalr | is_jal;

    // Ready in the last allowed cycle takes priority over the timeout
    assign timeout = TO_EN && (cnt_q == TO_LAST) && !mem_ready_i;

    always_comb begin
        imm_d = 3'd0;
        if (is_load || is_opimm || is_jalr) imm_d = 3'd1;
        else if (is_store)                  imm_d = 3'd2;
        else if (is_branch)                 imm_d = 3'd3;
        else if (is_lui || is_auipc)        imm_d = 3'd4;
        else if (is_jal)                    imm_d = 3'd5;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            cause_q <= 2'd0;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_q <= S_FETCH;
                    cnt_q   <= '0;
                end
                S_FETCH: begin
                    if (mem_ready_i) begin
                        state_q <= S_DECODE;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= S_TRAP;
                        cause_q <= 2'd2;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_TRAP;
                        cause_q <= 2'd1;
                    end
                end
                S_EXEC: begin
                    cnt_q <= '0;
                    if (is_load || is_store) state_q <= S_MEM;
                    else if (is_branch)      state_q <= S_FETCH;
                    else                     state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready_i) begin
                        state_q <= is_store ? S_FETCH : S_WB;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= S_TRAP;
                        cause_q <= 2'd3;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    cnt_q   <= '0;
                end
                S_TRAP: state_q <= S_TRAP;
                default: state_q <= S_RESET;
            endcase
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 2'd0;
        imm_sel_o   = 3'd0;
        alu_a_sel_o = 1'b0;
        alu_b_sel_o = 1'b0;
        wb_sel_o    = 2'd0;
        reg_we_o    = 1'b0;
        trap_o      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                ir_we_o   = mem_ready_i;
            end
            S_DECODE: imm_sel_o = imm_d;
            S_EXEC: begin
                imm_sel_o   = imm_d;
                alu_a_sel_o = is_auipc;
                alu_b_sel_o = !(is_op || is_branch);
                if (is_branch) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = {1'b0, branch_taken_i};
                end
            end
            S_MEM: begin
                imm_sel_o  = imm_d;
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                mem_we_o   = is_store;
                pc_we_o    = is_store && mem_ready_i;
            end
            S_WB: begin
                imm_sel_o = imm_d;
                reg_we_o  = 1'b1;
                pc_we_o   = 1'b1;
                if (is_load)                wb_sel_o = 2'd1;
                else if (is_jal || is_jalr) wb_sel_o = 2'd2;
                else if (is_lui)            wb_sel_o = 2'd3;
                if (is_jal)                 pc_sel_o = 2'd1;
                else if (is_jalr)           pc_sel_o = 2'd2;
            end
            S_TRAP: trap_o = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause_o = cause_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int TO   = 4;
    localparam int MAXL = 512;
    localparam int HOLD = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic [6:0] opcode_i = '0;
    logic branch_taken_i = 1'b0;
    logic mem_ready_i = 1'b0;
    logic mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o;
    logic [1:0] pc_sel_o;
    logic [2:0] imm_sel_o;
    logic alu_a_sel_o, alu_b_sel_o;
    logic [1:0] wb_sel_o;
    logic reg_we_o, trap_o;
    logic [1:0] trap_cause_o;
    logic [2:0] state_o;

    always #5 clk_i = ~clk_i;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i),
        .branch_taken_i(branch_taken_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .addr_sel_o(addr_sel_o),
        .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
        .imm_sel_o(imm_sel_o), .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o),
        .wb_sel_o(wb_sel_o), .reg_we_o(reg_we_o), .trap_o(trap_o),
        .trap_cause_o(trap_cause_o), .state_o(state_o)
    );

    typedef struct { logic [6:0] op; int fd; int md; logic tk; } ins_t;
    typedef struct { int cyc; logic [20:0] vec; int reqn; } ev_t;

    ins_t prog[$];
    ev_t  evq[$];
    logic       rdy_s[MAXL];
    logic [6:0] op_s[MAXL];
    logic       tk_s[MAXL];
    logic [6:0] legal_ops[9];
    int seg_len;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [1:0] trap_cause_exp = 2'd0;

    logic [20:0] act_vec;
    assign act_vec = {state_o, mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_sel_o,
                      imm_sel_o, alu_a_sel_o, alu_b_sel_o, wb_sel_o, reg_we_o, trap_o, trap_cause_o};

    function automatic logic [20:0] mkv(logic [2:0] st, logic req, logic we, logic as, logic ir,
                                        logic pcw, logic [1:0] pcs, logic [2:0] imm, logic aa,
                                        logic ab, logic [1:0] wb, logic rw, logic tr, logic [1:0] cs);
        return {st, req, we, as, ir, pcw, pcs, imm, aa, ab, wb, rw, tr, cs};
    endfunction

    function automatic logic [63:0] pack(int c, int r, logic [20:0] v);
        return {19'b0, 16'(c), 8'(r), v};
    endfunction

    function automatic bit is_legal(logic [6:0] op);
        return op inside {OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                          OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
    endfunction

    function automatic logic [2:0] imm_of(logic [6:0] op);
        case (op)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: return 3'd1;
            OPC_STORE:                     return 3'd2;
            OPC_BRANCH:                    return 3'd3;
            OPC_LUI, OPC_AUIPC:            return 3'd4;
            OPC_JAL:                       return 3'd5;
            default:                       return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] wb_of(logic [6:0] op);
        case (op)
            OPC_LOAD:           return 2'd1;
            OPC_JAL, OPC_JALR:  return 2'd2;
            OPC_LUI:            return 2'd3;
            default:            return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] npc_of(logic [6:0] op);
        return (op == OPC_JAL) ? 2'd1 : (op == OPC_JALR) ? 2'd2 : 2'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [20:0] v, input int r);
        ev_t e;
        e.cyc = c; e.vec = v; e.reqn = r;
        evq.push_back(e);
    endtask

    task automatic add(input logic [6:0] op, input int fd, input int md, input logic tk);
        ins_t i;
        i.op = op; i.fd = fd; i.md = md; i.tk = tk;
        prog.push_back(i);
    endtask

    // Turns the instruction list into per-cycle input schedules and the expected event timeline
    task automatic build();
        int t, s, e, m0, nxt;
        bit done, st;
        logic [6:0] op;
        evq.delete();
        for (int k = 0; k < MAXL; k++) begin
            rdy_s[k] = 1'($urandom_range(0, 1));
            op_s[k]  = 7'($urandom_range(0, 127));
            tk_s[k]  = 1'($urandom_range(0, 1));
        end
        t = 1; done = 0; seg_len = 0;
        foreach (prog[i]) if (!done) begin
            s = t; op = prog[i].op; st = (op == OPC_STORE); nxt = s + 1;
            if (prog[i].fd >= TO) begin
                for (int k = s; k < s + TO; k++) rdy_s[k] = 1'b0;
                push(s + TO, mkv(6, 0,0,0,0,0,0,0,0,0,0,0, 1, 2'd2), TO);
                seg_len = s + TO + HOLD; nxt = seg_len; done = 1;
            end else begin
                for (int k = s; k < s + prog[i].fd; k++) rdy_s[k] = 1'b0;
                rdy_s[s + prog[i].fd] = 1'b1;
                push(s + prog[i].fd, mkv(1, 1,0,0,1,0,0,0,0,0,0,0,0,0), prog[i].fd + 1);
                e = s + prog[i].fd + 2;
                if (!is_legal(op)) begin
                    push(e, mkv(6, 0,0,0,0,0,0,0,0,0,0,0, 1, 2'd1), 0);
                    seg_len = e + HOLD; nxt = seg_len; done = 1;
                end else begin
                    tk_s[e] = prog[i].tk;
                    push(e, mkv(3, 0,0,0,0, op == OPC_BRANCH,
                                (op == OPC_BRANCH) ? {1'b0, prog[i].tk} : 2'd0, imm_of(op),
                                op == OPC_AUIPC, !(op == OPC_OP || op == OPC_BRANCH), 0,0,0,0), 0);
                    if (op == OPC_BRANCH) begin
                        nxt = e + 1;
                    end else if (op == OPC_LOAD || st) begin
                        m0 = e + 1;
                        if (prog[i].md < 0) begin
                            rdy_s[m0] = 1'b0; rdy_s[m0 + 1] = 1'b0;
                            seg_len = m0 + 2; nxt = seg_len; done = 1;
                        end else if (prog[i].md >= TO) begin
                            for (int k = m0; k < m0 + TO; k++) rdy_s[k] = 1'b0;
                            push(m0 + TO, mkv(6, 0,0,0,0,0,0,0,0,0,0,0, 1, 2'd3), TO);
                            seg_len = m0 + TO + HOLD; nxt = seg_len; done = 1;
                        end else begin
                            for (int k = m0; k < m0 + prog[i].md; k++) rdy_s[k] = 1'b0;
                            rdy_s[m0 + prog[i].md] = 1'b1;
                            push(m0 + prog[i].md, mkv(4, 1, st, 1, 0, st, 0, imm_of(op), 0,0,0,0,0,0),
                                 prog[i].md + 1);
                            if (st) nxt = m0 + prog[i].md + 1;
                            else begin
                                push(m0 + prog[i].md + 1, mkv(5, 0,0,0,0, 1, npc_of(op), imm_of(op),
                                     0,0, wb_of(op), 1, 0, 0), 0);
                                nxt = m0 + prog[i].md + 2;
                            end
                        end
                    end else begin
                        push(e + 1, mkv(5, 0,0,0,0, 1, npc_of(op), imm_of(op), 0,0, wb_of(op), 1, 0, 0), 0);
                        nxt = e + 2;
                    end
                end
            end
            for (int k = s; k < nxt; k++) op_s[k] = op;
            t = nxt;
        end
        if (!done) begin
            rdy_s[t] = 1'b0;
            seg_len = t + 1;
        end
    endtask

    task automatic apply(input int c);
        mem_ready_i    = rdy_s[c];
        opcode_i       = op_s[c];
        branch_taken_i = tk_s[c];
    endtask

    task automatic run_segment();
        build();
        apply(0);
        @(posedge clk_i);
        #1;
        cyc = 0;
        rst_ni = 1'b1;
        for (int c = 1; c < seg_len; c++) begin
            @(posedge clk_i);
            #1;
            cyc = c;
            apply(c);
        end
        #1 rst_ni = 1'b0;
        #1 chk("reset_abort", 64'(act_vec), 64'd0);
        chk("drain", 64'(evq.size()), 64'd0);
        evq.delete();
        prog.delete();
        repeat (2) @(posedge clk_i);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a strobe, an EXEC cycle or trap entry
    int req_run = 0;
    logic [2:0] prev_st = 3'd0;
    bit trap_seen = 0;
    always @(negedge clk_i) begin
        int run;
        bit trig;
        ev_t e;
        if (!rst_ni) begin
            req_run = 0; prev_st = 3'd0; trap_seen = 0;
        end else begin
            run = mem_req_o ? ((state_o == prev_st) ? req_run + 1 : 1) : 0;
            trig = ir_we_o || pc_we_o || reg_we_o || (state_o == 3'd3) ||
                   (state_o == 3'd4 && mem_ready_i) || (state_o == 3'd6 && !trap_seen);
            if (cyc == 0) chk("reset_idle", 64'(act_vec), 64'd0);
            if (trig) begin
                if (evq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_event: got %h at cycle %0d, expected no event", act_vec, cyc);
                end else begin
                    e = evq.pop_front();
                    chk("event", pack(cyc, (state_o == 3'd6) ? req_run : run, act_vec),
                        pack(e.cyc, e.reqn, e.vec));
                    if (e.vec[20:18] == 3'd6) begin
                        trap_seen = 1;
                        trap_cause_exp = e.vec[1:0];
                    end
                end
            end else if (state_o == 3'd6) begin
                chk("trap_idle", 64'(act_vec), 64'(mkv(6, 0,0,0,0,0,0,0,0,0,0,0, 1, trap_cause_exp)));
            end
            req_run = run;
            prev_st = state_o;
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        legal_ops = '{OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL};
        repeat (3) @(posedge clk_i);
        #1 chk("reset_state", 64'(act_vec), 64'd0);

        add(OPC_OPIMM, 0, 0, 0); add(OPC_OPIMM, 0, 0, 0);
        add(OPC_LOAD, 0, 3, 0);  add(OPC_STORE, 1, 0, 0);
        add(OPC_BRANCH, 0, 0, 1); add(OPC_BRANCH, 2, 0, 0);
        add(OPC_JAL, 0, 0, 0);   add(OPC_JALR, 0, 0, 0);
        add(OPC_LUI, 0, 0, 0);   add(OPC_AUIPC, 3, 0, 0);
        add(OPC_OP, 0, 2, 0);    add(7'b1110011, 0, 0, 0);
        run_segment();

        add(OPC_OPIMM, 3, 0, 0); add(OPC_OPIMM, 4, 0, 0);
        run_segment();

        add(OPC_STORE, 0, 3, 0); add(OPC_LOAD, 0, 4, 0);
        run_segment();

        add(OPC_OPIMM, 0, 0, 0); add(OPC_LOAD, 1, -1, 0);
        run_segment();

        for (int sgi = 0; sgi < 10; sgi++) begin
            for (int n = 0; n < 15; n++) begin
                logic [6:0] op;
                if ($urandom_range(0, 19) == 0) begin
                    op = 7'($urandom_range(0, 127));
                    while (is_legal(op)) op = 7'($urandom_range(0, 127));
                end else begin
                    op = legal_ops[$urandom_range(0, 8)];
                end
                add(op, ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            end
            run_segment();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
